// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: steps the shared round datapath through the
// initial AddRoundKey and rounds 1..NR, fetching each round key before launching the round.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int SB_LAT  = 1,
  parameter int MIX_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       key_ack,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       busy,
  output logic       key_req,
  output logic [3:0] key_round,
  output logic       dp_load_init,
  output logic       dp_launch,
  output logic       dp_bypass_mix,
  output logic       dp_capture,
  output logic       out_valid
);

  typedef enum logic [2:0] {IDLE, KEY, INIT, RUN, CAP, DONE} state_t;

  localparam logic [3:0] NR_W        = 4'(NR);
  localparam logic [3:0] LAT_FULL_M1 = 4'(SB_LAT + MIX_LAT - 1);
  localparam logic [3:0] LAT_LAST_M1 = 4'(SB_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] round, round_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last_round;
  logic [3:0] lat_m1;

  // The final round skips MixColumns, so its datapath latency is shorter.
  assign last_round = (round == NR_W);
  assign lat_m1     = last_round ? LAT_LAST_M1 : LAT_FULL_M1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      round <= round_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    round_nxt = round;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = KEY;
        round_nxt = '0;
      end
      KEY: if (key_ack) begin
        if (round == 4'd0) begin
          state_nxt = INIT;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = lat_m1;
        end
      end
      INIT: begin
        state_nxt = KEY;
        round_nxt = 4'd1;
      end
      RUN: begin
        if (cnt == 4'd0) state_nxt = CAP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      CAP: begin
        if (last_round) begin
          state_nxt = DONE;
        end else begin
          state_nxt = KEY;
          round_nxt = round + 4'd1;
        end
      end
      DONE: if (out_ready) begin
        state_nxt = IDLE;
        round_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
    // Cancel overrides every other transition; the datapath state reg is left as is.
    if (abort) begin
      state_nxt = IDLE;
      round_nxt = '0;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    in_ready      = (state == IDLE);
    busy          = (state != IDLE);
    key_req       = (state == KEY);
    key_round     = round;
    dp_load_init  = (state == INIT);
    // cnt is loaded with L-1 on RUN entry, so this marks the first RUN cycle only.
    dp_launch     = (state == RUN) && (cnt == lat_m1);
    dp_bypass_mix = ((state == RUN) || (state == CAP)) && last_round;
    dp_capture    = (state == CAP);
    out_valid     = (state == DONE);
  end

endmodule
